// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select and the IF/ID register.
// Instruction memory is external and combinational: pc_f goes out, instr_f comes back in the same cycle.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_pc,
    input  logic [31:0] j_pc,
    input  logic [31:0] jr_pc,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] ir_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic [31:0] pc8_d,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(4 * IM_WORDS);

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] next_pc;
    logic        bad_f;

    assign pc_plus4 = pc_f + 32'd4;
    assign pc_plus8 = pc_f + 32'd8;

    // Misaligned or outside the IM window: the fetched word is discarded as a NOP.
    assign bad_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f >= IM_LIMIT);

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = br_pc;
            2'b10:   next_pc = j_pc;
            2'b11:   next_pc = jr_pc;
            default: next_pc = pc_plus4;
        endcase
    end

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f      <= PC_RESET;
            ir_d      <= 32'd0;
            pc_d      <= PC_RESET;
            pc4_d     <= PC_RESET + 32'd4;
            pc8_d     <= PC_RESET + 32'd8;
            fetch_err <= 1'b0;
            fetch_cnt <= 32'd0;
        end else if (!stall) begin
            pc_f      <= next_pc;
            ir_d      <= bad_f ? 32'd0 : instr_f;
            pc_d      <= pc_f;
            pc4_d     <= pc_plus4;
            pc8_d     <= pc_plus8;
            fetch_cnt <= fetch_cnt + 32'd1;
            if (bad_f) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes the expected IF/ID state per edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic [31:0] jr_pc;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [31:0] pc8_d;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_ir, m_pcd, m_pc4, m_pc8, m_cnt;
    logic        m_err;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
        .br_pc(br_pc), .j_pc(j_pc), .jr_pc(jr_pc), .instr_f(instr_f),
        .pc_f(pc_f), .ir_d(ir_d), .pc_d(pc_d), .pc4_d(pc4_d), .pc8_d(pc8_d),
        .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'h2400_0000 | {16'h0000, a[15:0]};
    endfunction

    // One clock: drive inputs, advance the model, push expectation, compare after the edge.
    task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                        input logic [31:0] br, input logic [31:0] j, input logic [31:0] jr,
                        input logic [31:0] word);
        exp_t e;
        exp_t got;
        logic bad;
        logic [31:0] npc;
        @(negedge clk);
        reset = rst; stall = st; npc_sel = sel;
        br_pc = br; j_pc = j; jr_pc = jr; instr_f = word;
        if (rst) begin
            m_pc = 32'h3000; m_ir = 32'd0; m_pcd = 32'h3000;
            m_pc4 = 32'h3004; m_pc8 = 32'h3008; m_err = 1'b0; m_cnt = 32'd0;
        end else if (!st) begin
            bad = (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc >= 32'h4000);
            case (sel)
                2'b01:   npc = br;
                2'b10:   npc = j;
                2'b11:   npc = jr;
                default: npc = m_pc + 32'd4;
            endcase
            m_ir  = bad ? 32'd0 : word;
            m_pcd = m_pc;
            m_pc4 = m_pc + 32'd4;
            m_pc8 = m_pc + 32'd8;
            m_cnt = m_cnt + 32'd1;
            if (bad) m_err = 1'b1;
            m_pc  = npc;
        end
        e = '{m_pc, m_ir, m_pcd, m_pc4, m_pc8, m_err, m_cnt};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check("pc_f", pc_f, got.pc);
            check("ir_d", ir_d, got.ir);
            check("pc_d", pc_d, got.pcd);
            check("pc4_d", pc4_d, got.pc4);
            check("pc8_d", pc8_d, got.pc8);
            check("fetch_err", {31'd0, fetch_err}, {31'd0, got.err});
            check("fetch_cnt", fetch_cnt, got.cnt);
        end
    endtask

    task automatic seq(input logic [31:0] word);
        step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, word);
    endtask

    initial begin
        int guard;
        reset = 1'b1; stall = 1'b0; npc_sel = 2'b00;
        br_pc = '0; j_pc = '0; jr_pc = '0; instr_f = '0;

        // Reset for two cycles, then the first fetch
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        check("rst_pc_f", pc_f, 32'h3000);
        check("rst_pc8_d", pc8_d, 32'h3008);
        seq(32'h2408_0001);
        check("tp1_pc_f", pc_f, 32'h3004);
        check("tp1_ir_d", ir_d, 32'h2408_0001);
        check("tp1_cnt", fetch_cnt, 32'd1);
        seq(im_word(m_pc));

        // Stall holds everything while a jump is presented
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'b10, 32'd0, 32'h3100, 32'd0, 32'hDEAD_BEEF);
        check("stall_pc_f", pc_f, 32'h3008);
        check("stall_cnt", fetch_cnt, 32'd2);
        step(1'b0, 1'b0, 2'b10, 32'd0, 32'h3100, 32'd0, im_word(m_pc));
        check("jmp_pc_f", pc_f, 32'h3100);

        // Branch redirect; delay slot fetched at 0x3100 still reaches ID
        step(1'b0, 1'b0, 2'b01, 32'h3040, 32'd0, 32'd0, 32'h1111_2222);
        check("br_pc_f", pc_f, 32'h3040);
        check("br_slot", ir_d, 32'h1111_2222);
        seq(im_word(m_pc));
        check("br_next", pc_f, 32'h3044);

        // jr to a misaligned target
        step(1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'h3002, im_word(m_pc));
        check("jr_pc_f", pc_f, 32'h3002);
        check("jr_err0", {31'd0, fetch_err}, 32'd0);
        step(1'b0, 1'b0, 2'b10, 32'd0, 32'h3010, 32'd0, 32'hFFFF_FFFF);
        check("mis_ir", ir_d, 32'd0);
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 3; i++) seq(im_word(m_pc));
        check("sticky", {31'd0, fetch_err}, 32'd1);

        // Clear, then run off the top of the IM window
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 2'b10, 32'd0, 32'h3FF0, 32'd0, im_word(m_pc));
        guard = 0;
        while (m_pc != 32'h4000 && guard < 16) begin
            seq(im_word(m_pc));
            guard++;
        end
        check("top_pc_f", pc_f, 32'h4000);
        check("top_ir_last", ir_d, im_word(32'h3FFC));
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 32'h1234_5678);
        check("stall_no_err", {31'd0, fetch_err}, 32'd0);
        seq(32'h1234_5678);
        check("oor_ir", ir_d, 32'd0);
        check("oor_err", {31'd0, fetch_err}, 32'd1);

        // Reset wins over stall and clears the sticky flag
        step(1'b1, 1'b1, 2'b11, 32'd0, 32'd0, 32'h5000, 32'h1);
        check("rst2_err", {31'd0, fetch_err}, 32'd0);
        check("rst2_cnt", fetch_cnt, 32'd0);
        check("rst2_pc4", pc4_d, 32'h3004);
        step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'h2408_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
